// File: rtl/axicb_slv_wr_order.sv
// ---------------------------------------------------------------------------
// axicb_slv_wr_order
//
// Write-data scheduler for one slave port of the crossbar. Every accepted AW
// pushes the index of its master into an order FIFO. The W channel is granted
// to the master at the FIFO head until that burst's WLAST is accepted. This
// keeps W data in AW order. wch_grant drives the W mux in the slave switch.
//
// Optional feature macro: AXICB_WR_ORDER_BYPASS_EN
//   Defined   : when the FIFO is empty, an AW handshake grants W in the same
//               cycle (wch_grant = aw_grant). If that burst also completes in
//               the same cycle, nothing is pushed.
//   Undefined : wch_grant is decoded from registers only. AW->W latency is
//               1 cycle, and there is no combinational path from aw_grant.
//
// Handshake semantics: a W beat is taken when the granted master has wvalid
// set and the slave has wready set (whs). A burst retires (pop) on a whs
// cycle in which the granted master's wlast is also set. An AW entry is
// pushed on aw_hshake, unless the FIFO is registered-full.
//
// Ports
//   aclk, areset  clock, asynchronous active-high reset
//   aw_grant      one-hot grant of the AW arbiter
//   aw_hshake     AW handshake at the slave side (push strobe)
//   aw_full       order FIFO full; the switch masks AW while it is set
//   i_wvalid      wvalid from each master
//   i_wlast       wlast from each master
//   o_wready      wready from the slave
//   wch_grant     one-hot W owner; 0 = no owner
//   wr_pending    FIFO occupancy
//   w_beats       beats accepted in the current burst, saturates at 255
//   w_state       0 IDLE, 1 WAIT, 2 BURST
// ---------------------------------------------------------------------------
module axicb_slv_wr_order #(
  parameter int MST_NB      = 4,
  parameter int ORDER_DEPTH = 8
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic [MST_NB-1:0]            aw_grant,
  input  logic                         aw_hshake,
  output logic                         aw_full,
  input  logic [MST_NB-1:0]            i_wvalid,
  input  logic [MST_NB-1:0]            i_wlast,
  input  logic                         o_wready,
  output logic [MST_NB-1:0]            wch_grant,
  output logic [$clog2(ORDER_DEPTH):0] wr_pending,
  output logic [7:0]                   w_beats,
  output logic [1:0]                   w_state
);

  localparam int IDX_W = (MST_NB > 1) ? $clog2(MST_NB) : 1;
  localparam int PTR_W = $clog2(ORDER_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

  logic [IDX_W-1:0]  fifo_q [ORDER_DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [7:0]        beats_q, beats_d;

  logic [IDX_W-1:0]  aw_idx;
  logic [IDX_W-1:0]  head_idx;
  logic [MST_NB-1:0] head_grant;
  logic              fifo_empty;
  logic              whs;
  logic              wlast_g;
  logic              pop;
  logic              pop_fifo;
  logic              bypass_pop;
  logic              push;

  assign fifo_empty = (count_q == '0);
  assign aw_full    = (count_q == CNT_W'(ORDER_DEPTH));
  assign head_idx   = fifo_q[rd_ptr_q];

  always_comb begin
    aw_idx = '0;
    for (int i = 0; i < MST_NB; i++) begin
      if (aw_grant[i]) aw_idx = aw_idx | IDX_W'(i);
    end
  end

  always_comb begin
    head_grant = '0;
    for (int i = 0; i < MST_NB; i++) begin
      head_grant[i] = !fifo_empty && (head_idx == IDX_W'(i));
    end
  end

`ifdef AXICB_WR_ORDER_BYPASS_EN
  assign wch_grant = (fifo_empty && aw_hshake) ? aw_grant : head_grant;
`else
  assign wch_grant = head_grant;
`endif

  assign whs     = (|(wch_grant & i_wvalid)) & o_wready;
  assign wlast_g = |(wch_grant & i_wlast);
  assign pop     = whs & wlast_g;

  // A pop with an empty FIFO can only be a bypassed burst finishing in its
  // own AW cycle: it consumes the AW entry instead of the FIFO head.
  assign pop_fifo   = pop & !fifo_empty;
  assign bypass_pop = pop & fifo_empty;

  // Full is judged on the registered count, so a pop in the full cycle does
  // not make room for a same-cycle push.
  assign push = aw_hshake & !aw_full & !bypass_pop;

  always_comb begin
    rd_ptr_d = pop_fifo ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = push     ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop_fifo);
  end

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    if (pop) begin
      beats_d = '0;
      state_d = (count_d != '0) ? ST_WAIT : ST_IDLE;
    end else if (whs) begin
      if (beats_q != 8'hFF) beats_d = beats_q + 8'd1;
      state_d = ST_BURST;
    end else if ((state_q == ST_IDLE) && (count_d != '0)) begin
      state_d = ST_WAIT;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= ST_IDLE;
      beats_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      beats_q  <= beats_d;
    end
  end

  // Storage needs no reset: an entry is only read while count covers it.
  always_ff @(posedge aclk) begin
    if (push) fifo_q[wr_ptr_q] <= aw_idx;
  end

  assign wr_pending = count_q;
  assign w_beats    = beats_q;
  assign w_state    = state_q;

  a_aw_onehot: assert property (@(posedge aclk) disable iff (areset)
    aw_hshake |-> $onehot(aw_grant))
    else $error("aw_grant is not one-hot on aw_hshake");

  // The dropped-entry behaviour is defined, so this one only warns.
  a_no_push_full: assert property (@(posedge aclk) disable iff (areset)
    aw_hshake |-> !aw_full)
    else $warning("aw_hshake while order FIFO is full; entry dropped");

endmodule

// File: tb/tb_axicb_slv_wr_order.sv
module tb_axicb_slv_wr_order;

  localparam int MST   = 4;
  localparam int DEPTH = 4;
`ifdef AXICB_WR_ORDER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       aclk = 1'b0;
  logic       areset;
  logic [3:0] aw_grant;
  logic       aw_hshake;
  logic       aw_full;
  logic [3:0] i_wvalid;
  logic [3:0] i_wlast;
  logic       o_wready;
  logic [3:0] wch_grant;
  logic [2:0] wr_pending;
  logic [7:0] w_beats;
  logic [1:0] w_state;

  int checks = 0;
  int errors = 0;

  // Reference model: the AW order as a queue of master indices plus the
  // beat count of the burst at its head.
  logic [1:0] exp_q[$];
  int         m_beats = 0;

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  axicb_slv_wr_order #(.MST_NB(MST), .ORDER_DEPTH(DEPTH)) dut (
    .aclk       (aclk),
    .areset     (areset),
    .aw_grant   (aw_grant),
    .aw_hshake  (aw_hshake),
    .aw_full    (aw_full),
    .i_wvalid   (i_wvalid),
    .i_wlast    (i_wlast),
    .o_wready   (o_wready),
    .wch_grant  (wch_grant),
    .wr_pending (wr_pending),
    .w_beats    (w_beats),
    .w_state    (w_state)
  );

  // ---------------- model ----------------
  function automatic logic [1:0] enc(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return 2'(i);
    return 2'd0;
  endfunction

  function automatic logic [3:0] m_grant();
    if (exp_q.size() != 0) return 4'(1 << exp_q[0]);
    if (BYP && aw_hshake) return aw_grant;
    return 4'b0000;
  endfunction

  function automatic logic [1:0] m_state();
    if (exp_q.size() == 0) return 2'd0;
    return (m_beats > 0) ? 2'd2 : 2'd1;
  endfunction

  task automatic model_clock();
    logic [3:0] g;
    bit was_empty, full, beat, last;
    g         = m_grant();
    was_empty = (exp_q.size() == 0);
    full      = (exp_q.size() == DEPTH);
    beat      = ((g & i_wvalid) != 4'b0) && o_wready;
    last      = ((g & i_wlast) != 4'b0);
    if (beat && last) begin
      if (!was_empty) exp_q.delete(0);
      m_beats = 0;
    end else if (beat) begin
      m_beats = (m_beats < 255) ? m_beats + 1 : 255;
    end
    if (aw_hshake && !full && !(was_empty && beat && last))
      exp_q.push_back(enc(aw_grant));
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    aw_grant  = 4'b0;
    aw_hshake = 1'b0;
    i_wvalid  = 4'b0;
    i_wlast   = 4'b0;
    o_wready  = 1'b0;
  endtask

  task automatic settle();
    @(negedge aclk);
  endtask

  task automatic tick();
    model_clock();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_aw(input int m);
    idle();
    aw_grant  = 4'(1 << m);
    aw_hshake = 1'b1;
    settle();
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    areset = 1'b1;
    idle();
    #1;
    checks++; if (wch_grant !== 4'b0) begin errors++; $display("FAIL rst_grant: got %0h exp 0", wch_grant); end
    checks++; if (aw_full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b exp 0", aw_full); end
    checks++; if (wr_pending !== 3'd0) begin errors++; $display("FAIL rst_pending: got %0d exp 0", wr_pending); end
    checks++; if (w_beats !== 8'd0) begin errors++; $display("FAIL rst_beats: got %0d exp 0", w_beats); end
    checks++; if (w_state !== 2'd0) begin errors++; $display("FAIL rst_state: got %0d exp 0", w_state); end
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    areset = 1'b0;
    exp_q.delete();
    m_beats = 0;
  endtask

  task automatic test_single_master();
    bit mst0_seen = 1'b0;
    idle();
    aw_grant = 4'b0100; aw_hshake = 1'b1; i_wvalid = 4'b0001; o_wready = 1'b1;
    settle();
    checks++; if (wch_grant !== m_grant()) begin errors++; $display("FAIL t2_aw_grant: got %0h exp %0h", wch_grant, m_grant()); end
    if (wch_grant[0]) mst0_seen = 1'b1;
    tick();
    aw_grant = 4'b0; aw_hshake = 1'b0;
    for (int b = 0; b < 4; b++) begin
      i_wvalid = 4'b0101;
      i_wlast  = (b == 3) ? 4'b0101 : 4'b0001;
      settle();
      checks++; if (wch_grant !== 4'b0100) begin errors++; $display("FAIL t2_grant: beat %0d got %0h exp 4", b, wch_grant); end
      checks++; if (w_beats !== 8'(b)) begin errors++; $display("FAIL t2_beats: got %0d exp %0d", w_beats, b); end
      checks++; if (w_state !== m_state()) begin errors++; $display("FAIL t2_state: got %0d exp %0d", w_state, m_state()); end
      if (wch_grant[0]) mst0_seen = 1'b1;
      tick();
    end
    i_wvalid = 4'b0001; i_wlast = 4'b0001;
    settle();
    if (wch_grant[0]) mst0_seen = 1'b1;
    checks++; if (wch_grant !== 4'b0) begin errors++; $display("FAIL t2_grant_after: got %0h exp 0", wch_grant); end
    checks++; if (w_beats !== 8'd0) begin errors++; $display("FAIL t2_beats_after: got %0d exp 0", w_beats); end
    checks++; if (mst0_seen !== 1'b0) begin errors++; $display("FAIL t2_mst0: got granted exp never"); end
    tick();
    idle();
  endtask

  task automatic test_back_to_back();
    int order[3] = '{1, 3, 0};
    int mb[4] = '{0, 0, 0, 0};
    for (int i = 0; i < 3; i++) begin
      idle();
      aw_grant = 4'(1 << order[i]); aw_hshake = 1'b1;
      settle();
      checks++; if (wch_grant !== m_grant()) begin errors++; $display("FAIL t3_aw_grant: got %0h exp %0h", wch_grant, m_grant()); end
      tick();
    end
    idle();
    i_wvalid = 4'hF; o_wready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      for (int m = 0; m < 4; m++) i_wlast[m] = (mb[m] == 1);
      settle();
      checks++; if (wch_grant !== 4'(1 << order[c/2])) begin errors++; $display("FAIL t3_grant: cycle %0d got %0h exp %0h", c, wch_grant, 4'(1 << order[c/2])); end
      checks++; if (wr_pending !== 3'(3 - c/2)) begin errors++; $display("FAIL t3_pending: got %0d exp %0d", wr_pending, 3 - c/2); end
      for (int m = 0; m < 4; m++) if (wch_grant[m]) mb[m] = (mb[m] + 1) % 2;
      tick();
    end
    idle();
    settle();
    checks++; if (wr_pending !== 3'd0) begin errors++; $display("FAIL t3_drained: got %0d exp 0", wr_pending); end
    checks++; if (wch_grant !== 4'b0) begin errors++; $display("FAIL t3_grant_end: got %0h exp 0", wch_grant); end
    tick();
  endtask

  task automatic test_full();
    int mst[4];
    for (int i = 0; i < 4; i++) begin
      mst[i] = $urandom_range(0, 3);
      push_aw(mst[i]);
    end
    idle();
    settle();
    checks++; if (aw_full !== 1'b1) begin errors++; $display("FAIL t4_full: got %0b exp 1", aw_full); end
    checks++; if (wr_pending !== 3'd4) begin errors++; $display("FAIL t4_pending: got %0d exp 4", wr_pending); end
    tick();
    // illegal push while full: must be dropped
    aw_grant = 4'(1 << $urandom_range(0, 3)); aw_hshake = 1'b1;
    settle();
    tick();
    idle();
    settle();
    checks++; if (wr_pending !== 3'd4) begin errors++; $display("FAIL t4_drop: got %0d exp 4", wr_pending); end
    tick();
    // head completes a single-beat burst while another AW is attempted
    i_wvalid = 4'(1 << mst[0]); i_wlast = 4'(1 << mst[0]); o_wready = 1'b1;
    aw_grant = 4'(1 << $urandom_range(0, 3)); aw_hshake = 1'b1;
    settle();
    checks++; if (aw_full !== 1'b1) begin errors++; $display("FAIL t4_full_popcyc: got %0b exp 1", aw_full); end
    checks++; if (wch_grant !== 4'(1 << mst[0])) begin errors++; $display("FAIL t4_head: got %0h exp %0h", wch_grant, 4'(1 << mst[0])); end
    tick();
    idle();
    settle();
    checks++; if (aw_full !== 1'b0) begin errors++; $display("FAIL t4_full_fall: got %0b exp 0", aw_full); end
    checks++; if (wr_pending !== 3'd3) begin errors++; $display("FAIL t4_after_pop: got %0d exp 3", wr_pending); end
    tick();
    for (int k = 1; k < 4; k++) begin
      i_wvalid = 4'hF; i_wlast = 4'hF; o_wready = 1'b1;
      settle();
      checks++; if (wch_grant !== 4'(1 << mst[k])) begin errors++; $display("FAIL t4_drain: entry %0d got %0h exp %0h", k, wch_grant, 4'(1 << mst[k])); end
      tick();
    end
    idle();
    settle();
    checks++; if (wr_pending !== 3'd0) begin errors++; $display("FAIL t4_empty: got %0d exp 0", wr_pending); end
    tick();
  endtask

  task automatic test_random();
    int mlen[4][$];
    int mdone[4] = '{0, 0, 0, 0};
    logic [1:0] sb_q[$];
    int issued = 0, completed = 0, cyc = 0, aw_m = 0;
    while (completed < 20 && cyc < 3000) begin
      idle();
      if (issued < 20 && exp_q.size() < DEPTH && $urandom_range(0, 2) != 0) begin
        aw_m = $urandom_range(0, 3);
        aw_grant = 4'(1 << aw_m); aw_hshake = 1'b1;
      end
      for (int m = 0; m < 4; m++) begin
        i_wvalid[m] = (mlen[m].size() != 0) && ($urandom_range(0, 3) != 0);
        i_wlast[m]  = (mlen[m].size() != 0) && (mdone[m] + 1 == mlen[m][0]);
      end
      o_wready = ($urandom_range(0, 4) != 0);
      settle();
      checks++; if (wch_grant !== m_grant()) begin errors++; $display("FAIL t5_grant: cycle %0d got %0h exp %0h", cyc, wch_grant, m_grant()); end
      checks++; if (wr_pending !== 3'(exp_q.size())) begin errors++; $display("FAIL t5_pending: cycle %0d got %0d exp %0d", cyc, wr_pending, exp_q.size()); end
      for (int m = 0; m < 4; m++) begin
        if (wch_grant[m] && i_wvalid[m] && o_wready) begin
          mdone[m]++;
          if (i_wlast[m]) begin
            checks++;
            if (sb_q.size() == 0 || sb_q[0] !== 2'(m)) begin
              errors++; $display("FAIL t5_order: burst from %0d exp %0d", m, (sb_q.size() != 0) ? int'(sb_q[0]) : -1);
            end
            if (sb_q.size() != 0) sb_q.delete(0);
            mlen[m].delete(0);
            mdone[m] = 0;
            completed++;
          end
        end
      end
      if (aw_hshake) begin
        mlen[aw_m].push_back($urandom_range(1, 4));
        sb_q.push_back(2'(aw_m));
        issued++;
      end
      tick();
      cyc++;
    end
    idle();
    checks++; if (completed != 20) begin errors++; $display("FAIL t5_timeout: completed %0d exp 20", completed); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL t5_leftover: got %0d exp 0", sb_q.size()); end
  endtask

  task automatic test_saturate();
    push_aw(3);
    idle();
    i_wvalid = 4'b1000; o_wready = 1'b1;
    for (int b = 0; b < 300; b++) begin
      settle();
      tick();
    end
    settle();
    checks++; if (w_beats !== 8'd255) begin errors++; $display("FAIL sat_beats: got %0d exp 255", w_beats); end
    checks++; if (w_state !== 2'd2) begin errors++; $display("FAIL sat_state: got %0d exp 2", w_state); end
    i_wlast = 4'b1000;
    tick();
    idle();
    settle();
    checks++; if (w_beats !== 8'd0) begin errors++; $display("FAIL sat_clear: got %0d exp 0", w_beats); end
    checks++; if (w_state !== 2'd0) begin errors++; $display("FAIL sat_idle: got %0d exp 0", w_state); end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    aw_grant = 4'b0010; aw_hshake = 1'b1;
    i_wvalid = 4'b0010; i_wlast = 4'b0010; o_wready = 1'b1;
    settle();
`ifdef AXICB_WR_ORDER_BYPASS_EN
    checks++; if (wch_grant !== 4'b0010) begin errors++; $display("FAIL t6_same_cycle: got %0h exp 2", wch_grant); end
    tick();
    idle();
    settle();
    checks++; if (wr_pending !== 3'd0) begin errors++; $display("FAIL t6_pending: got %0d exp 0", wr_pending); end
    checks++; if (wch_grant !== 4'b0) begin errors++; $display("FAIL t6_grant_after: got %0h exp 0", wch_grant); end
    tick();
`else
    checks++; if (wch_grant !== 4'b0) begin errors++; $display("FAIL t6_same_cycle: got %0h exp 0", wch_grant); end
    tick();
    aw_grant = 4'b0; aw_hshake = 1'b0;
    settle();
    checks++; if (wch_grant !== 4'b0010) begin errors++; $display("FAIL t6_next_cycle: got %0h exp 2", wch_grant); end
    checks++; if (wr_pending !== 3'd1) begin errors++; $display("FAIL t6_pending1: got %0d exp 1", wr_pending); end
    tick();
    idle();
    settle();
    checks++; if (wr_pending !== 3'd0) begin errors++; $display("FAIL t6_pending0: got %0d exp 0", wr_pending); end
    tick();
`endif
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 4; i++) push_aw($urandom_range(0, 3));
    idle();
    i_wvalid = 4'hF; o_wready = 1'b1;
    settle();
    tick();
    areset = 1'b1;
    #1;
    checks++; if (wch_grant !== 4'b0) begin errors++; $display("FAIL mid_rst_grant: got %0h exp 0", wch_grant); end
    checks++; if (aw_full !== 1'b0) begin errors++; $display("FAIL mid_rst_full: got %0b exp 0", aw_full); end
    checks++; if (wr_pending !== 3'd0) begin errors++; $display("FAIL mid_rst_pending: got %0d exp 0", wr_pending); end
    checks++; if (w_state !== 2'd0) begin errors++; $display("FAIL mid_rst_state: got %0d exp 0", w_state); end
    checks++; if (w_beats !== 8'd0) begin errors++; $display("FAIL mid_rst_beats: got %0d exp 0", w_beats); end
    idle();
    exp_q.delete();
    m_beats = 0;
    @(posedge aclk); #1;
    areset = 1'b0;
    settle();
    checks++; if (wr_pending !== 3'd0) begin errors++; $display("FAIL mid_rst_release: got %0d exp 0", wr_pending); end
    tick();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_master();
    test_back_to_back();
    test_full();
    test_random();
    test_saturate();
    test_bypass();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
